vehicle_detect_cond: RTL and testbench

Conditions the two raw inductive-loop detector inputs for the traffic light controller: synchronises, debounces and latches each into a demand request (MD, SD). Each request is held until the controller shows service. It sits directly upstream of the traffic light controller on the same clock, and its MD/SD outputs drive the controller's MD/SD inputs. Service acknowledgements are the controller's own MA and SG light outputs, fed back.

---
 rtl/tlc_pkg.sv | 18 +
 rtl/det_channel.sv | 133 +++++++++++++
 rtl/vehicle_detect_cond.sv | 51 +++++
 tb/tb_vehicle_detect_cond.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared constants for the traffic light controller front end: debounce/stuck
// defaults, counter widths and channel indices.
package tlc_pkg;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int STUCK_CYCLES_DEF = 1024;
  localparam int DEB_CNT_W        = 4;
  localparam int STUCK_CNT_W      = 16;

  localparam logic CH_MAIN = 1'b0;
  localparam logic CH_SIDE = 1'b1;

  typedef struct packed {
    logic req;
    logic stuck;
  } det_status_t;

endpackage

// File: rtl/det_channel.sv
// One loop-detector channel: 2-flop synchroniser, debounce filter, service
// request latch and, with DETECT_STUCK_EN defined, stuck-high recall.
module det_channel
  import tlc_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw,
  input  logic        ack,
  output det_status_t status
);

  if ((DEB_CYCLES < 2) || (DEB_CYCLES > 15) ||
      (STUCK_CYCLES < 16) || (STUCK_CYCLES > 65535)) begin : g_bad_param
    $error("det_channel: DEB_CYCLES or STUCK_CYCLES out of range");
  end

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 s1_r;
  logic                 s2_r;
  logic                 filt_r;
  logic                 filt_s;
  logic [DEB_CNT_W-1:0] cnt_r;
  logic [DEB_CNT_W-1:0] cnt_s;
  logic                 req_r;
  logic                 req_s;
  logic                 stuck_s;

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
    end
  end

  // Debounce: any agreeing sample restarts the run of disagreements.
  always_comb begin
    filt_s = filt_r;
    cnt_s  = {DEB_CNT_W{1'b0}};
    if (s2_r == filt_r) begin
      cnt_s = {DEB_CNT_W{1'b0}};
    end else if (cnt_r == DEB_LAST) begin
      filt_s = s2_r;
      cnt_s  = {DEB_CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + {{(DEB_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= 1'b0;
      cnt_r  <= {DEB_CNT_W{1'b0}};
    end else begin
      filt_r <= filt_s;
      cnt_r  <= cnt_s;
    end
  end

`ifdef DETECT_STUCK_EN
  localparam logic [STUCK_CNT_W-1:0] STUCK_LIM = STUCK_CNT_W'(STUCK_CYCLES);

  logic [STUCK_CNT_W-1:0] scnt_r;
  logic [STUCK_CNT_W-1:0] scnt_s;
  logic                   stuck_r;
  logic                   stuck_nxt_s;

  // Stuck counter: saturating count of filtered-high cycles.
  always_comb begin
    scnt_s      = scnt_r;
    stuck_nxt_s = stuck_r;
    if (!filt_r) begin
      scnt_s      = {STUCK_CNT_W{1'b0}};
      stuck_nxt_s = 1'b0;
    end else if (scnt_r == STUCK_LIM) begin
      scnt_s      = scnt_r;
      stuck_nxt_s = 1'b1;
    end else begin
      scnt_s      = scnt_r + {{(STUCK_CNT_W-1){1'b0}}, 1'b1};
      stuck_nxt_s = (scnt_s == STUCK_LIM);
    end
  end

  // Stuck counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_r  <= {STUCK_CNT_W{1'b0}};
      stuck_r <= 1'b0;
    end else begin
      scnt_r  <= scnt_s;
      stuck_r <= stuck_nxt_s;
    end
  end

  assign stuck_s = stuck_r;
`else
  assign stuck_s = 1'b0;
`endif

  // Request latch: service acknowledge always wins over a new demand.
  always_comb begin
    req_s = req_r;
    if (ack) begin
      req_s = 1'b0;
    end else if (filt_r || stuck_s) begin
      req_s = 1'b1;
    end else begin
      req_s = req_r;
    end
  end

  // Request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r <= 1'b0;
    end else begin
      req_r <= req_s;
    end
  end

  assign status.req   = req_r;
  assign status.stuck = stuck_s;

endmodule

// File: rtl/vehicle_detect_cond.sv
// Conditions the main and side loop detectors into MD/SD demand requests.
// Optional stuck-loop recall is built when DETECT_STUCK_EN is defined.
module vehicle_detect_cond
  import tlc_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic CLK,
  input  logic clr_n,
  input  logic MLOOP,
  input  logic SLOOP,
  input  logic MA,
  input  logic SG,
  output logic MD,
  output logic SD,
  output logic MSTUCK,
  output logic SSTUCK
);

  det_status_t main_status_s;
  det_status_t side_status_s;

  det_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_main (
    .clk   (CLK),
    .rst_n (clr_n),
    .raw   (MLOOP),
    .ack   (MA),
    .status(main_status_s)
  );

  det_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_side (
    .clk   (CLK),
    .rst_n (clr_n),
    .raw   (SLOOP),
    .ack   (SG),
    .status(side_status_s)
  );

  assign MD     = main_status_s.req;
  assign SD     = side_status_s.req;
  assign MSTUCK = main_status_s.stuck;
  assign SSTUCK = side_status_s.stuck;

endmodule

// File: tb/tb_vehicle_detect_cond.sv
// Self-checking bench for vehicle_detect_cond: directed scenarios plus a
// randomized run against a window-based behavioural model.
module tb_vehicle_detect_cond;
  import tlc_pkg::*;

  localparam int DEB = DEB_CYCLES_DEF;
  localparam int STK = STUCK_CYCLES_DEF;

  logic CLK = 1'b0;
  logic clr_n = 1'b0;
  logic MLOOP = 1'b0;
  logic SLOOP = 1'b0;
  logic MA = 1'b0;
  logic SG = 1'b0;
  logic MD, SD, MSTUCK, SSTUCK;

  int checks = 0;
  int passed = 0;

  // Model state: raw history (bit0 = newest), synchronised sample history,
  // filtered level, request, and length of the current filtered-high run.
  logic [1:0]  raw_hist  [2];
  logic [15:0] samp_hist [2];
  logic        m_filt    [2];
  logic        m_req     [2];
  logic        m_stuck   [2];
  int          m_run     [2];

  vehicle_detect_cond dut (
    .CLK(CLK), .clr_n(clr_n), .MLOOP(MLOOP), .SLOOP(SLOOP), .MA(MA), .SG(SG),
    .MD(MD), .SD(SD), .MSTUCK(MSTUCK), .SSTUCK(SSTUCK)
  );

  always #5 CLK = ~CLK;

  task automatic model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      logic raw, ack, samp, all_diff, nreq;
      raw = (ch == int'(CH_MAIN)) ? MLOOP : SLOOP;
      ack = (ch == int'(CH_MAIN)) ? MA : SG;
      if (!clr_n) begin
        raw_hist[ch] = 2'b00; samp_hist[ch] = 16'h0000;
        m_filt[ch] = 1'b0; m_req[ch] = 1'b0; m_stuck[ch] = 1'b0; m_run[ch] = 0;
      end else begin
        samp = raw_hist[ch][1];
        samp_hist[ch] = {samp_hist[ch][14:0], samp};
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++)
          if (samp_hist[ch][i] == m_filt[ch]) all_diff = 1'b0;
        nreq = ack ? 1'b0 : ((m_filt[ch] || m_stuck[ch]) ? 1'b1 : m_req[ch]);
`ifdef DETECT_STUCK_EN
        m_run[ch]   = m_filt[ch] ? ((m_run[ch] + 1 > STK) ? STK : m_run[ch] + 1) : 0;
        m_stuck[ch] = (m_run[ch] == STK);
`endif
        m_req[ch] = nreq;
        if (all_diff) m_filt[ch] = ~m_filt[ch];
        raw_hist[ch] = {raw_hist[ch][0], raw};
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_edge();
      #1;
    end
  endtask

  task automatic do_reset();
    MLOOP = 1'b0; SLOOP = 1'b0; MA = 1'b0; SG = 1'b0;
    clr_n = 1'b0;
    step(2);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    MLOOP = 1'b0; SLOOP = 1'b0; MA = 1'b0; SG = 1'b0; clr_n = 1'b0;
    step(3);
    checks++; if ({MD, SD, MSTUCK, SSTUCK} !== 4'b0000) $display("FAIL reset_state got=%b exp=0000", {MD, SD, MSTUCK, SSTUCK}); else passed++;
    clr_n = 1'b1;
    MLOOP = 1'b1;
    step(7);
    checks++; if (MD !== 1'b1) $display("FAIL reset_md_rise got=%b exp=1", MD); else passed++;
    MLOOP = 1'b0;
    step(4);
    checks++; if (MD !== 1'b1) $display("FAIL reset_md_latched got=%b exp=1", MD); else passed++;
    #2 clr_n = 1'b0;
    #1;
    checks++; if ({MD, SD, MSTUCK, SSTUCK} !== 4'b0000) $display("FAIL async_clear got=%b exp=0000", {MD, SD, MSTUCK, SSTUCK}); else passed++;
    step(1);
    clr_n = 1'b1;
    SLOOP = 1'b1;
    step(6);
    checks++; if (SD !== 1'b0) $display("FAIL sd_latency_early got=%b exp=0", SD); else passed++;
    step(1);
    checks++; if (SD !== 1'b1) $display("FAIL sd_latency_7 got=%b exp=1", SD); else passed++;
    SLOOP = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    SLOOP = 1'b1; step(3); SLOOP = 1'b0;
    step(10);
    checks++; if (SD !== 1'b0) $display("FAIL glitch3_rejected got=%b exp=0", SD); else passed++;
    SLOOP = 1'b1; step(4); SLOOP = 1'b0;
    step(3);
    checks++; if (SD !== 1'b1) $display("FAIL pulse4_accepted got=%b exp=1", SD); else passed++;
    step(10);
    checks++; if (SD !== 1'b1) $display("FAIL pulse4_held got=%b exp=1", SD); else passed++;
  endtask

  task automatic test_service();
    SG = 1'b1; step(1);
    checks++; if (SD !== 1'b0) $display("FAIL service_clear got=%b exp=0", SD); else passed++;
    step(1);
    checks++; if (SD !== 1'b0) $display("FAIL service_hold got=%b exp=0", SD); else passed++;
    SG = 1'b0; step(5);
    checks++; if (SD !== 1'b0) $display("FAIL service_after got=%b exp=0", SD); else passed++;
  endtask

  task automatic test_persistent();
    do_reset();
    SLOOP = 1'b1; step(7);
    checks++; if (SD !== 1'b1) $display("FAIL persist_set got=%b exp=1", SD); else passed++;
    SG = 1'b1; step(1);
    checks++; if (SD !== 1'b0) $display("FAIL persist_ack got=%b exp=0", SD); else passed++;
    SG = 1'b0; step(1);
    checks++; if (SD !== 1'b1) $display("FAIL persist_reassert got=%b exp=1", SD); else passed++;
    SLOOP = 1'b0;
  endtask

  task automatic test_independence();
    do_reset();
    MLOOP = 1'b1; step(7);
    checks++; if ({MD, SD} !== 2'b10) $display("FAIL indep_md_only got=%b exp=10", {MD, SD}); else passed++;
    MLOOP = 1'b0; SLOOP = 1'b1; step(7);
    MA = 1'b1; step(1);
    checks++; if ({MD, SD} !== 2'b01) $display("FAIL indep_ma_clear got=%b exp=01", {MD, SD}); else passed++;
    MA = 1'b0; SLOOP = 1'b0;
  endtask

  task automatic test_stuck();
    do_reset();
    MLOOP = 1'b1;
`ifdef DETECT_STUCK_EN
    step(6 + STK - 1);
    checks++; if (MSTUCK !== 1'b0) $display("FAIL stuck_early got=%b exp=0", MSTUCK); else passed++;
    step(1);
    checks++; if (MSTUCK !== 1'b1) $display("FAIL stuck_set got=%b exp=1", MSTUCK); else passed++;
    MA = 1'b1; step(1);
    checks++; if (MD !== 1'b0) $display("FAIL stuck_ack got=%b exp=0", MD); else passed++;
    MA = 1'b0; step(1);
    checks++; if (MD !== 1'b1) $display("FAIL stuck_recall got=%b exp=1", MD); else passed++;
    MLOOP = 1'b0; step(6);
    checks++; if (MSTUCK !== 1'b1) $display("FAIL stuck_hold got=%b exp=1", MSTUCK); else passed++;
    step(1);
    checks++; if (MSTUCK !== 1'b0) $display("FAIL stuck_clear got=%b exp=0", MSTUCK); else passed++;
`else
    for (int i = 0; i < 11; i++) begin
      step(100);
      checks++; if (MSTUCK !== 1'b0) $display("FAIL nostuck_flag got=%b exp=0 cycle=%0d", MSTUCK, i * 100); else passed++;
    end
    MLOOP = 1'b0;
`endif
  endtask

  task automatic test_random();
    int mhold = 0;
    int shold = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (mhold == 0) begin MLOOP = 1'($urandom_range(0, 1)); mhold = $urandom_range(1, 8); end
      else mhold--;
      if (shold == 0) begin SLOOP = 1'($urandom_range(0, 1)); shold = $urandom_range(1, 8); end
      else shold--;
      MA = ($urandom_range(0, 9) == 0);
      SG = ($urandom_range(0, 9) == 0);
      step(1);
      checks++;
      if ({MD, SD, MSTUCK, SSTUCK} !== {m_req[CH_MAIN], m_req[CH_SIDE], m_stuck[CH_MAIN], m_stuck[CH_SIDE]})
        $display("FAIL random_cycle%0d got=%b exp=%b", i, {MD, SD, MSTUCK, SSTUCK},
                 {m_req[CH_MAIN], m_req[CH_SIDE], m_stuck[CH_MAIN], m_stuck[CH_SIDE]});
      else passed++;
    end
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      raw_hist[ch] = 2'b00; samp_hist[ch] = 16'h0000;
      m_filt[ch] = 1'b0; m_req[ch] = 1'b0; m_stuck[ch] = 1'b0; m_run[ch] = 0;
    end
    test_reset();
    test_glitch();
    test_service();
    test_persistent();
    test_independence();
    test_stuck();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
